// File: rtl/seq_wide_adder_ctrl.sv
// Multi-cycle wide adder built on one narrow carry-lookahead slice.
// Operands are added SLICE_BITS per cycle with a registered ripple carry.

module nBitCarryLookAheadAdder #(
  parameter int NUMBITS = 8
) (
  input  logic [NUMBITS-1:0] a,
  input  logic [NUMBITS-1:0] b,
  input  logic               c_in,
  output logic [NUMBITS-1:0] s_out,
  output logic               c_out
);
  localparam int NG = NUMBITS / 4;

  logic [NG:0] gc;

  assign gc[0] = c_in;

  // 4-bit lookahead groups, carry rippled between groups
  for (genvar k = 0; k < NG; k++) begin : g_grp
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    assign g    = a[4*k +: 4] & b[4*k +: 4];
    assign p    = a[4*k +: 4] ^ b[4*k +: 4];
    assign c[0] = gc[k];
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0])
                | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1])
                | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2])
                | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);
    assign s_out[4*k +: 4] = p ^ c[3:0];
    assign gc[k+1] = c[4];
  end

  assign c_out = gc[NG];
endmodule

module seq_wide_adder_ctrl #(
  parameter int TOTAL_BITS = 32,
  parameter int SLICE_BITS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [TOTAL_BITS-1:0] a_in,
  input  logic [TOTAL_BITS-1:0] b_in,
  input  logic                  c_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [TOTAL_BITS-1:0] s_out,
  output logic                  c_out,
  output logic                  ovf_out,
  output logic                  busy
);
  localparam int NSLICES = TOTAL_BITS / SLICE_BITS;
  localparam int IDXW =
    (NSLICES > 1) ? $clog2(NSLICES) : 1;
  localparam int MSB = TOTAL_BITS - 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [IDXW-1:0]       idx_q;
  logic                  carry_q;
  logic [TOTAL_BITS-1:0] a_q, b_q, s_q;
  logic                  c_q, ovf_q;

  logic [SLICE_BITS-1:0] a_sl, b_sl, sum_sl;
  logic                  cout_sl;
  logic                  last;

  assign a_sl = a_q[idx_q*SLICE_BITS +: SLICE_BITS];
  assign b_sl = b_q[idx_q*SLICE_BITS +: SLICE_BITS];
  assign last = (idx_q == IDXW'(NSLICES - 1));

  nBitCarryLookAheadAdder #(
    .NUMBITS(SLICE_BITS)
  ) u_cla (
    .a    (a_sl),
    .b    (b_sl),
    .c_in (carry_q),
    .s_out(sum_sl),
    .c_out(cout_sl)
  );

  // handshake status comes only from the state register
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);

  assign s_out   = s_q;
  assign c_out   = c_q;
  assign ovf_out = ovf_q;

  // next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (in_valid) state_d = S_RUN;
      S_RUN:  if (last) state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // state, operand capture and slice sequencing
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && in_valid) begin
        a_q     <= a_in;
        b_q     <= b_in;
        carry_q <= c_in;
        idx_q   <= '0;
      end else if (state_q == S_RUN) begin
        carry_q <= cout_sl;
        idx_q   <= idx_q + 1'b1;
      end
    end
  end

  // result collection; held through DONE backpressure
  always_ff @(posedge clk) begin
    if (reset) begin
      s_q   <= '0;
      c_q   <= 1'b0;
      ovf_q <= 1'b0;
    end else if (state_q == S_RUN) begin
      s_q[idx_q*SLICE_BITS +: SLICE_BITS] <= sum_sl;
      if (last) begin
        c_q   <= cout_sl;
        ovf_q <= (a_q[MSB] == b_q[MSB])
              && (sum_sl[SLICE_BITS-1] != a_q[MSB]);
      end
    end
  end
endmodule

// File: tb/tb_seq_wide_adder_ctrl.sv
// Self-checking bench for seq_wide_adder_ctrl (32-bit, 8-bit slices).
// Directed vector table, backpressure/reset sequences, random scoreboard.

module tb_seq_wide_adder_ctrl;
  localparam int TB = 32;
  localparam int NS = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [TB-1:0] a_in, b_in;
  logic          c_in;
  logic          out_valid;
  logic          out_ready;
  logic [TB-1:0] s_out;
  logic          c_out;
  logic          ovf_out;
  logic          busy;

  int tests = 0;
  int fails = 0;

  seq_wide_adder_ctrl #(
    .TOTAL_BITS(32),
    .SLICE_BITS(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_in     (a_in),
    .b_in     (b_in),
    .c_in     (c_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .s_out    (s_out),
    .c_out    (c_out),
    .ovf_out  (ovf_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic [31:0] s;
    logic        c;
    logic        ov;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // {ovf, carry, sum} from plain unsigned and signed arithmetic
  function automatic logic [33:0] model(
    input logic [31:0] a, input logic [31:0] b,
    input logic ci);
    logic [32:0] u;
    longint      sg;
    logic        ov;
    u  = {1'b0, a} + {1'b0, b} + {32'd0, ci};
    sg = longint'($signed(a)) + longint'($signed(b))
       + longint'(ci);
    ov = (sg > 64'sd2147483647) || (sg < -64'sd2147483648);
    return {ov, u};
  endfunction

  // one complete transaction with latency measurement
  task automatic do_add(input logic [31:0] a,
                        input logic [31:0] b,
                        input logic ci,
                        output logic [33:0] res,
                        output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    a_in = a;
    b_in = b;
    c_in = ci;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    res = {ovf_out, c_out, s_out};
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("after_hs_in_ready", 64'(in_ready), 64'd1);
    chk("after_hs_out_valid", 64'(out_valid), 64'd0);
  endtask

  logic [33:0] res;
  logic [33:0] held;
  logic [33:0] exp_q[$];
  int          lat;
  int          sent;
  int          rcv;

  initial begin
    vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0,
                32'h00000000, 1'b1, 1'b0};
    vecs[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0,
                32'h80000000, 1'b0, 1'b1};
    vecs[2] = '{32'h80000000, 32'h80000000, 1'b0,
                32'h00000000, 1'b1, 1'b1};
    vecs[3] = '{32'h12345678, 32'h0F0F0F0F, 1'b1,
                32'h21436588, 1'b0, 1'b0};
    vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1,
                32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[5] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1,
                32'hFFFFFFFF, 1'b0, 1'b1};

    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a_in = '0;
    b_in = '0;
    c_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_result", 64'({ovf_out, c_out, s_out}), 64'd0);
    reset = 1'b0;

    // directed vector table
    for (int i = 0; i < 6; i++) begin
      do_add(vecs[i].a, vecs[i].b, vecs[i].ci, res, lat);
      chk($sformatf("vec%0d_result", i), 64'(res),
          64'({vecs[i].ov, vecs[i].c, vecs[i].s}));
      chk($sformatf("vec%0d_latency", i), 64'(lat),
          64'(NS));
      chk($sformatf("vec%0d_busy", i), 64'(busy), 64'd1);
      release_out();
    end

    // long backpressure in DONE, in_valid pulses ignored
    do_add(32'h12345678, 32'h0F0F0F0F, 1'b1, held, lat);
    chk("bp_latency", 64'(lat), 64'(NS));
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      a_in = $urandom;
      b_in = $urandom;
      c_in = 1'($urandom_range(1));
      @(negedge clk);
      chk("bp_hold", 64'({ovf_out, c_out, s_out}), 64'(held));
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    release_out();

    // reset two slices into RUN aborts the add
    @(negedge clk);
    a_in = 32'hDEADBEEF;
    b_in = 32'h01234567;
    c_in = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_run_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_outputs", 64'({ovf_out, c_out, s_out}), 64'd0);
    repeat (6) @(negedge clk);
    chk("abort_no_result", 64'(out_valid), 64'd0);
    do_add(32'h89ABCDEF, 32'h76543210, 1'b1, res, lat);
    chk("post_abort_result", 64'(res),
        64'(model(32'h89ABCDEF, 32'h76543210, 1'b1)));
    chk("post_abort_latency", 64'(lat), 64'(NS));
    release_out();

    // random traffic against the scoreboard
    sent = 0;
    rcv = 0;
    for (int cyc = 0; cyc < 40000 && rcv < 1000; cyc++) begin
      @(negedge clk);
      in_valid = (sent < 1000) && ($urandom_range(3) != 0);
      a_in = $urandom;
      b_in = $urandom;
      c_in = 1'($urandom_range(1));
      out_ready = ($urandom_range(2) != 0);
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a_in, b_in, c_in));
        sent++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("rnd_spurious", 64'd1, 64'd0);
        end else begin
          chk($sformatf("rnd_result%0d", rcv),
              64'({ovf_out, c_out, s_out}),
              64'(exp_q.pop_front()));
        end
        rcv++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("rnd_received", 64'(rcv), 64'd1000);
    chk("rnd_sent", 64'(sent), 64'd1000);
    chk("rnd_leftover", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
